// File: rtl/fir_coef_sequencer.sv
// Coefficient/sample address sequencer for the time-multiplexed FIR MAC.
// Optional `SYMMETRIC_COEF_EN folds coef_addr for linear-phase filters (ROM holds ceil(N/2) words).
module fir_coef_sequencer #(
  parameter int COEF_WIDTH = 24,
  parameter int TAPS       = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int CH_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_taps,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic [ADDR_WIDTH-1:0] hist_addr,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [CH_WIDTH-1:0]   ch,
  output logic                  mac_valid,
  output logic                  mac_first,
  output logic                  mac_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [ADDR_WIDTH:0] TAPS_W  = (ADDR_WIDTH + 1)'(TAPS);
  localparam logic [CH_WIDTH-1:0] CH_LAST = CH_WIDTH'(CHANNELS - 1);

  if (COEF_WIDTH < 1 || TAPS > (1 << ADDR_WIDTH) || (1 << CH_WIDTH) < CHANNELS) begin : g_bad_params
    $error("fir_coef_sequencer: inconsistent parameters");
  end

  logic [0:0]            state, nxt_state;
  logic [ADDR_WIDTH-1:0] t, nxt_t;
  logic [CH_WIDTH-1:0]   c, nxt_c;
  logic [ADDR_WIDTH:0]   n_lat, nxt_n, n_eff;
  logic [ADDR_WIDTH-1:0] nxt_wr;
  logic [ADDR_WIDTH-1:0] nxt_coef;
  logic                  nxt_last;
  logic                  last_tap;
  logic                  start_in_run;

  assign n_eff        = (num_taps == '0 || num_taps > TAPS_W) ? TAPS_W : num_taps;
  assign last_tap     = ({1'b0, t} == n_lat - 1'b1);
  assign start_in_run = start && (state == RUN);

  // Next-state logic; the output registers are loaded from these values so every
  // output is registered yet tap 0 appears the cycle right after the accepting edge.
  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state = state;
    nxt_t     = t;
    nxt_c     = c;
    nxt_n     = n_lat;
    nxt_wr    = wr_ptr;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = RUN;
          nxt_t     = '0;
          nxt_c     = '0;
          nxt_n     = n_eff;
          nxt_wr    = wr_ptr + 1'b1;
        end
      end
      default: begin
        if (last_tap) begin
          nxt_t = '0;
          if (c == CH_LAST) nxt_state = IDLE;
          else              nxt_c     = c + 1'b1;
        end else begin
          nxt_t = t + 1'b1;
        end
      end
    endcase
  end

`ifdef SYMMETRIC_COEF_EN
  logic [ADDR_WIDTH:0] half_n;
  assign half_n = (nxt_n + 1'b1) >> 1;
  always_comb begin
    nxt_coef = nxt_t;
    if ({1'b0, nxt_t} >= half_n)
      nxt_coef = ADDR_WIDTH'(nxt_n - 1'b1 - {1'b0, nxt_t});
  end
`else
  assign nxt_coef = nxt_t;
`endif

  assign nxt_last = ({1'b0, nxt_t} == nxt_n - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      t         <= '0;
      c         <= '0;
      n_lat     <= TAPS_W;
      wr_ptr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      coef_addr <= '0;
      hist_addr <= '0;
      ch        <= '0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end else begin
      state     <= nxt_state;
      t         <= nxt_t;
      c         <= nxt_c;
      n_lat     <= nxt_n;
      wr_ptr    <= nxt_wr;
      busy      <= (nxt_state == RUN);
      mac_valid <= (nxt_state == RUN);
      done      <= (state == RUN) && (nxt_state == IDLE);

      // A new overrun event beats a simultaneous clear.
      if (start_in_run)     overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;

      if (nxt_state == RUN) begin
        coef_addr <= nxt_coef;
        hist_addr <= nxt_wr - nxt_t;
        ch        <= nxt_c;
        mac_first <= (nxt_t == '0);
        mac_last  <= nxt_last;
      end else begin
        coef_addr <= '0;
        hist_addr <= '0;
        ch        <= '0;
        mac_first <= 1'b0;
        mac_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Scoreboard bench for fir_coef_sequencer: stimulus pushes expected MAC beats,
// a negedge monitor pops and compares them whenever mac_valid is high.
module tb_fir_coef_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] num_taps = '0;
  logic       clr_overrun = 1'b0;
  logic       busy, done, overrun, mac_valid, mac_first, mac_last;
  logic [7:0] coef_addr, hist_addr, wr_ptr;
  logic [0:0] ch;

  fir_coef_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_taps(num_taps),
    .busy(busy), .done(done), .overrun(overrun), .clr_overrun(clr_overrun),
    .coef_addr(coef_addr), .hist_addr(hist_addr), .wr_ptr(wr_ptr), .ch(ch),
    .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_wr   = 0;
  logic [18:0] sbq[$];   // {coef, hist, ch, first, last}

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected beats for one sequence, built tap by tap from the behavioural rules.
  task automatic push_seq(input int n, input int wr);
    for (int cc = 0; cc < 2; cc++) begin
      for (int tt = 0; tt < n; tt++) begin
        int coef;
        coef = tt;
`ifdef SYMMETRIC_COEF_EN
        if (tt >= (n + 1) / 2) coef = n - 1 - tt;
`endif
        sbq.push_back({coef[7:0], 8'((wr - tt) & 255), cc[0], (tt == 0), (tt == n - 1)});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mac_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_mac_valid", 1, 0);
      end else begin
        logic [18:0] e;
        e = sbq.pop_front();
        check("mac_beat", int'({coef_addr, hist_addr, ch, mac_first, mac_last}), int'(e));
      end
    end
  end

  // Inputs are driven on the negedge; start is taken on the following posedge.
  task automatic pulse_start(input logic [8:0] nt, input int n_eff);
    exp_wr = (exp_wr + 1) % 256;
    push_seq(n_eff, exp_wr);
    start = 1'b1;
    num_taps = nt;
    @(negedge clk);
    start = 1'b0;
    check("wr_ptr_after_start", int'(wr_ptr), exp_wr);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int cnt0, input int expc, input string name);
    int cnt;
    cnt = cnt0;
    while (!done && cnt < expc + 20) begin
      @(negedge clk);
      cnt++;
    end
    check(name, done ? cnt : -1, expc);
    check("busy_low_on_done", int'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    sbq.delete();
    exp_wr = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int done_seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_outputs", int'({busy, done, overrun, mac_valid, mac_first, mac_last, ch,
                               coef_addr, hist_addr, wr_ptr}), 0);

    // Basic 4-tap, two-channel sequence: done 9 cycles after the accepting edge.
    pulse_start(9'd4, 4);
    wait_done(1, 9, "done_latency_n4");
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);

    // Three back-to-back 3-tap sequences from a fresh pointer (covers hist wrap 1,0,255).
    do_reset();
    pulse_start(9'd3, 3);
    wait_done(1, 7, "done_latency_n3_a");
    pulse_start(9'd3, 3);
    wait_done(1, 7, "done_latency_n3_b");
    pulse_start(9'd3, 3);
    wait_done(1, 7, "done_latency_n3_c");
    check("wr_ptr_third", int'(wr_ptr), 3);
    check("no_overrun_b2b", int'(overrun), 0);
    @(negedge clk);

    // Boundary tap counts.
    pulse_start(9'd0, 256);
    wait_done(1, 513, "done_latency_n0");
    pulse_start(9'd300, 256);
    wait_done(1, 513, "done_latency_n300");
    pulse_start(9'd1, 1);
    wait_done(1, 3, "done_latency_n1");
    pulse_start(9'd5, 5);
    wait_done(1, 11, "done_latency_n5");
    @(negedge clk);

    // Start while busy: ignored, overrun set, length and pointer untouched.
    pulse_start(9'd4, 4);
    @(negedge clk);
    start = 1'b1;
    num_taps = 9'd2;
    @(negedge clk);
    start = 1'b0;
    check("overrun_set", int'(overrun), 1);
    check("wr_ptr_unchanged", int'(wr_ptr), exp_wr);
    wait_done(3, 9, "done_latency_overrun");
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_cleared", int'(overrun), 0);

    // Clear coinciding with a new overrun event: set wins.
    pulse_start(9'd4, 4);
    start = 1'b1;
    clr_overrun = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_overrun = 1'b0;
    check("overrun_set_wins", int'(overrun), 1);
    wait_done(2, 9, "done_latency_set_wins");
    @(negedge clk);

    // Reset at tap 5 aborts with no done pulse.
    pulse_start(9'd8, 8);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", int'({busy, done, overrun, mac_valid, mac_first, mac_last, ch,
                                 coef_addr, hist_addr, wr_ptr}), 0);
    sbq.delete();
    exp_wr = 0;
    reset = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);

    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fir_coef_sequencer.md
Name: fir_coef_sequencer

Overview:
Multi-channel coefficient/sample address sequencer for the time-multiplexed FIR MAC in the Mercury receive chain.
- On each input-sample strobe, walks every tap of the filter once per channel.
- Drives the coefficient ROM address and the sample-history RAM address.
- Produces MAC control flags (valid, first, last, channel) and a completion pulse.
- Replaces the free-running single-shot tap counter with a start/busy/done handshake, runtime tap count and per-sample history pointer.

Parameters:
- COEF_WIDTH, 24, coefficient word width; carried for ROM sizing only, no datapath here.
- TAPS, 256, maximum filter length; must be ≤ 2^ADDR_WIDTH.
- ADDR_WIDTH, 8, width of the coefficient and history addresses.
- CHANNELS, 2, number of channels (I/Q or multiple receivers) processed per sample.
- CH_WIDTH, 1, channel index width; must satisfy 2^CH_WIDTH ≥ CHANNELS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle new-sample strobe.
- num_taps  in  ADDR_WIDTH+1  runtime tap count, latched on an accepted start.
- busy  out  1  high while a sequence is running.
- done  out  1  one-cycle pulse after the last tap of the last channel.
- overrun  out  1  sticky; set when start arrives while busy.
- clr_overrun  in  1  clears overrun.
- coef_addr  out  ADDR_WIDTH  coefficient ROM address.
- hist_addr  out  ADDR_WIDTH  sample-history RAM address.
- wr_ptr  out  ADDR_WIDTH  history write pointer for the incoming sample.
- ch  out  CH_WIDTH  channel index for the current tap.
- mac_valid  out  1  coef_addr, hist_addr and ch are valid this cycle.
- mac_first  out  1  first tap of a channel (accumulator clear).
- mac_last  out  1  last tap of a channel (accumulator dump).

Behaviour:
- All outputs are registered.
- Reset: every output is 0, state IDLE, wr_ptr 0, latched tap count = TAPS. Reset mid-sequence aborts immediately: no done pulse, wr_ptr returns to 0.
- States:
  - IDLE: busy 0. An accepted start moves to RUN.
  - RUN: busy 1. Leaves RUN after the final tap of the final channel.
- Start acceptance:
  - start is accepted in IDLE, including the cycle in which done is high.
  - On acceptance: latch effective tap count N, increment wr_ptr by 1 (mod 2^ADDR_WIDTH), set t=0, c=0.
- Effective tap count N: num_taps==0 gives N=TAPS; num_taps>TAPS gives N=TAPS; otherwise N=num_taps.
- Start while busy: ignored, overrun set. The sequence and wr_ptr are unaffected.
- clr_overrun: clears overrun. If it coincides with a new overrun event, set wins.
- Output timing:
  - Start accepted on edge k, so the first mac_valid is in cycle k+1.
  - One tap per clock; mac_valid stays high for exactly N×CHANNELS consecutive cycles.
- Per valid cycle:
  - coef_addr = t.
  - hist_addr = wr_ptr − t (mod 2^ADDR_WIDTH), using the updated wr_ptr, so tap 0 addresses the newest sample.
  - ch = c.
  - mac_first = (t==0).
  - mac_last = (t==N−1).
  - When N==1, mac_first and mac_last are both high.
- Advance: t increments each cycle. At t==N−1, t wraps to 0 and c increments. At t==N−1 with c==CHANNELS−1, the state goes to IDLE.
- done: high exactly one cycle, in the cycle immediately after the last mac_valid. busy falls in the same cycle.
- ROM/RAM latency belongs downstream: the consumer delays mac_* by its memory read latency. This block does not compensate.

Optional Feature:
- Macro SYMMETRIC_COEF_EN.
- Defined: coefficient folding for linear-phase filters. coef_addr = t for t < ceil(N/2), else N−1−t, so the ROM holds only ceil(N/2) words. hist_addr, flags and timing are unchanged.
- Not defined: coef_addr = t for all taps.

Test Plan:
- Reset, then start with num_taps=4, CHANNELS=2:
  - mac_valid for 8 cycles starting cycle k+1.
  - coef_addr 0,1,2,3,0,1,2,3; ch 0,0,0,0,1,1,1,1.
  - mac_first on tap 0 of each channel, mac_last on tap 3 of each channel.
  - done in cycle k+9.
- Three starts each issued on the done cycle, num_taps=3:
  - wr_ptr = 1, 2, 3.
  - On the third sequence, hist_addr = 3, 2, 1 per channel.
  - No idle gap between sequences; overrun stays 0.
- wr_ptr=0 before start, num_taps=3: wr_ptr becomes 1, hist_addr = 1, 0, 255 (wrap-around).
- Boundary tap counts:
  - num_taps=0 and num_taps=300: 256 taps per channel.
  - num_taps=1: first and last both high on each of the 2 valid cycles.
- Overrun:
  - start during RUN: overrun=1, sequence length and wr_ptr unchanged.
  - clr_overrun coincident with a new start during RUN: overrun stays 1.
  - reset at tap 5: all outputs 0 next cycle, no done pulse.
- SYMMETRIC_COEF_EN defined, num_taps=5: coef_addr = 0,1,2,1,0 per channel.
